// File: rtl/adc_window_average.sv
// ---------------------------------------------------------------------------
// adc_window_average
//
// Sliding-window averager for the current and voltage ADC sample streams.
// The last 2^LOG2_DEPTH accepted samples of each channel are kept in a
// circular buffer together with a running sum. Once the window is full,
// every accepted sample produces a new floor(mean) on both channels, one
// registered stage after the sum update, flagged by a one-cycle avg_valid.
//
// Ports:
//   clk            system clock (100 MHz domain)
//   rst_n          asynchronous active-low reset
//   sample_valid   one-cycle strobe, new sample on sample_current/voltage
//   sample_current unsigned current sample
//   sample_voltage unsigned voltage sample
//   clear          synchronous flush of window and outputs (beats a sample)
//   avg_current    windowed mean of current
//   avg_voltage    windowed mean of voltage
//   avg_valid      one-cycle strobe, averages updated this cycle
//   window_full    high once DEPTH samples accepted since reset/clear
// ---------------------------------------------------------------------------
module adc_window_average #(
    parameter int DATA_W     = 16,
    parameter int LOG2_DEPTH = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_current,
    input  logic [DATA_W-1:0] sample_voltage,
    input  logic              clear,
    output logic [DATA_W-1:0] avg_current,
    output logic [DATA_W-1:0] avg_voltage,
    output logic              avg_valid,
    output logic              window_full
);

    localparam int DEPTH  = 1 << LOG2_DEPTH;
    localparam int SUM_W  = DATA_W + LOG2_DEPTH;
    localparam int N_CH   = 2;
    localparam logic [LOG2_DEPTH:0] FILL_LAST = (LOG2_DEPTH + 1)'(DEPTH - 1);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state_reg, state_next;
    logic [LOG2_DEPTH-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [LOG2_DEPTH:0]     fill_cnt_reg, fill_cnt_next;
    logic                    window_full_reg, window_full_next;
    logic                    avg_pend_reg, avg_pend_next;
    logic                    avg_valid_reg;
    logic                    accept;

    logic [N_CH-1:0][DATA_W-1:0] sample_ch;
    logic [N_CH-1:0][DATA_W-1:0] avg_ch;

    assign accept       = sample_valid & ~clear;
    assign sample_ch[0] = sample_current;
    assign sample_ch[1] = sample_voltage;

    // -----------------------------------------------------------------------
    // Shared control: write pointer, fill counter, FSM and valid path. Both
    // channels use these, which keeps them time-aligned.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= FILL;
            wr_ptr_reg      <= '0;
            fill_cnt_reg    <= '0;
            window_full_reg <= 1'b0;
            avg_pend_reg    <= 1'b0;
            avg_valid_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            wr_ptr_reg      <= wr_ptr_next;
            fill_cnt_reg    <= fill_cnt_next;
            window_full_reg <= window_full_next;
            avg_pend_reg    <= avg_pend_next;
            // A clear also kills an average that is pending from last edge.
            avg_valid_reg   <= avg_pend_reg & ~clear;
        end
    end

    always_comb begin
        state_next       = state_reg;
        wr_ptr_next      = wr_ptr_reg;
        fill_cnt_next    = fill_cnt_reg;
        window_full_next = window_full_reg;
        avg_pend_next    = 1'b0;
        if (clear) begin
            state_next       = FILL;
            wr_ptr_next      = '0;
            fill_cnt_next    = '0;
            window_full_next = 1'b0;
        end else if (accept) begin
            // DEPTH is a power of two, so the pointer wraps on its own.
            wr_ptr_next = wr_ptr_reg + 1'b1;
            case (state_reg)
                FILL: begin
                    fill_cnt_next = fill_cnt_reg + 1'b1;
                    if (fill_cnt_reg == FILL_LAST) begin
                        state_next       = RUN;
                        window_full_next = 1'b1;
                        avg_pend_next    = 1'b1;
                    end
                end
                RUN: begin
                    avg_pend_next = 1'b1;
                end
                default: begin
                    state_next = FILL;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Per-channel datapath: circular buffer, running sum, average register.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [DATA_W-1:0] mem [DEPTH];
            logic [DATA_W-1:0] old_sample;
            logic [SUM_W-1:0]  sum_reg, sum_next;
            logic [DATA_W-1:0] avg_reg;

            // The oldest entry must be visible in the same cycle it gets
            // overwritten, so the read is asynchronous (distributed RAM).
            always_ff @(posedge clk) begin
                if (accept) begin
                    mem[wr_ptr_reg] <= sample_ch[gi];
                end
            end

            assign old_sample = mem[wr_ptr_reg];

            // During FILL the slot under wr_ptr holds stale data from before
            // the last reset/clear, so nothing is subtracted until RUN.
            always_comb begin
                sum_next = sum_reg;
                if (clear) begin
                    sum_next = '0;
                end else if (accept) begin
                    sum_next = sum_reg + SUM_W'(sample_ch[gi])
                             - ((state_reg == RUN) ? SUM_W'(old_sample) : '0);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_reg <= '0;
                    avg_reg <= '0;
                end else begin
                    sum_reg <= sum_next;
                    if (clear) begin
                        avg_reg <= '0;
                    end else if (avg_pend_reg) begin
                        avg_reg <= sum_reg[SUM_W-1:LOG2_DEPTH];
                    end
                end
            end

            assign avg_ch[gi] = avg_reg;
        end
    endgenerate

    assign avg_current = avg_ch[0];
    assign avg_voltage = avg_ch[1];
    assign avg_valid   = avg_valid_reg;
    assign window_full = window_full_reg;

endmodule

// File: tb/tb_adc_window_average.sv
// ---------------------------------------------------------------------------
// tb_adc_window_average
//
// Scoreboard bench for adc_window_average (DATA_W=16, LOG2_DEPTH=3).
// A queue-based window model computes the expected average for every
// accepted sample once DEPTH samples are held; the expectation, with the
// cycle it is due on, is queued when the sample is driven and popped when
// the DUT raises avg_valid. Held averages and window_full are compared
// every cycle.
// ---------------------------------------------------------------------------
module tb_adc_window_average;

    localparam int DATA_W     = 16;
    localparam int LOG2_DEPTH = 3;
    localparam int DEPTH      = 1 << LOG2_DEPTH;

    logic              clk;
    logic              rst_n;
    logic              sample_valid;
    logic [DATA_W-1:0] sample_current;
    logic [DATA_W-1:0] sample_voltage;
    logic              clear;
    logic [DATA_W-1:0] avg_current;
    logic [DATA_W-1:0] avg_voltage;
    logic              avg_valid;
    logic              window_full;

    adc_window_average #(
        .DATA_W    (DATA_W),
        .LOG2_DEPTH(LOG2_DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sample_valid  (sample_valid),
        .sample_current(sample_current),
        .sample_voltage(sample_voltage),
        .clear         (clear),
        .avg_current   (avg_current),
        .avg_voltage   (avg_voltage),
        .avg_valid     (avg_valid),
        .window_full   (window_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int                due;
        logic [DATA_W-1:0] c;
        logic [DATA_W-1:0] v;
    } exp_t;

    exp_t sb[$];
    int   win_c[$];
    int   win_v[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic              model_full = 1'b0;
    logic [DATA_W-1:0] held_c = '0;
    logic [DATA_W-1:0] held_v = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     tag, act, act, exp, exp, cyc);
        end
    endtask

    // Window model: accepted sample enters, oldest leaves beyond DEPTH.
    task automatic model_accept(input logic [DATA_W-1:0] c, input logic [DATA_W-1:0] v);
        exp_t e;
        int   sc;
        int   sv;
        win_c.push_back(int'(c));
        win_v.push_back(int'(v));
        if (win_c.size() > DEPTH) begin
            void'(win_c.pop_front());
            void'(win_v.pop_front());
        end
        if (win_c.size() == DEPTH) begin
            model_full = 1'b1;
            sc = 0;
            sv = 0;
            foreach (win_c[i]) sc += win_c[i];
            foreach (win_v[i]) sv += win_v[i];
            e.due = cyc + 2;
            e.c   = DATA_W'(sc / DEPTH);
            e.v   = DATA_W'(sv / DEPTH);
            sb.push_back(e);
        end
    endtask

    // Flush on clear/reset: window emptied, anything not yet seen is dropped.
    task automatic model_flush();
        win_c.delete();
        win_v.delete();
        model_full = 1'b0;
        held_c     = '0;
        held_v     = '0;
        while (sb.size() > 0 && sb[sb.size()-1].due > cyc) void'(sb.pop_back());
    endtask

    task automatic send(input logic [DATA_W-1:0] c, input logic [DATA_W-1:0] v);
        @(negedge clk);
        clear          = 1'b0;
        sample_valid   = 1'b1;
        sample_current = c;
        sample_voltage = v;
        model_accept(c, v);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            clear        = 1'b0;
            sample_valid = 1'b0;
        end
    endtask

    task automatic do_clear(input logic with_sample, input logic [DATA_W-1:0] c);
        @(negedge clk);
        clear          = 1'b1;
        sample_valid   = with_sample;
        sample_current = c;
        sample_voltage = c;
        model_flush();
    endtask

    // Output monitor, sampled just after each active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (sb.size() > 0 && sb[0].due < cyc) begin
                    check("missing_valid", 0, 1);
                    void'(sb.pop_front());
                end
                if (avg_valid) begin
                    if (sb.size() == 0) begin
                        check("spurious_valid", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("valid_cycle", cyc, e.due);
                        held_c = e.c;
                        held_v = e.v;
                        $display("txn cycle %0d avg_current=%0d avg_voltage=%0d (exp %0d %0d)",
                                 cyc, avg_current, avg_voltage, e.c, e.v);
                    end
                end
                check("avg_current", avg_current, held_c);
                check("avg_voltage", avg_voltage, held_v);
                check("window_full", window_full, model_full);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gaps[4];
        gaps = '{1, 5, 17, 0};

        rst_n          = 1'b0;
        sample_valid   = 1'b0;
        sample_current = '0;
        sample_voltage = '0;
        clear          = 1'b0;
        #12;
        check("reset_avg_current", avg_current, 0);
        check("reset_avg_voltage", avg_voltage, 0);
        check("reset_avg_valid", avg_valid, 0);
        check("reset_window_full", window_full, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Fill with a constant; first average after the 8th strobe.
        for (int i = 0; i < DEPTH; i++) send(16'd10, 16'd100);
        idle(3);
        check("fill_avg_current", avg_current, 10);
        check("fill_avg_voltage", avg_voltage, 100);

        // Ramp 1..16 on current, voltage 0.
        for (int i = 1; i <= 16; i++) send(16'(i), 16'd0);
        idle(3);
        check("ramp_final", avg_current, 12);

        // Full scale, then zeros: no overflow, falling averages.
        for (int i = 0; i < DEPTH; i++) send(16'hFFFF, 16'hFFFF);
        idle(3);
        check("fullscale_avg", avg_current, 16'hFFFF);
        for (int i = 0; i < DEPTH; i++) send(16'h0000, 16'h0000);
        idle(3);
        check("zero_avg", avg_voltage, 0);

        // Clear coincident with a sample of 500, pending average suppressed.
        for (int i = 0; i < DEPTH; i++) send(16'd7, 16'd7);
        do_clear(1'b1, 16'd500);
        idle(1);
        check("clear_window_full", window_full, 0);
        check("clear_avg_valid", avg_valid, 0);
        check("clear_avg_current", avg_current, 0);
        for (int i = 0; i < DEPTH; i++) send(16'd3, 16'd3);
        idle(3);
        check("post_clear_avg", avg_current, 3);

        // Irregularly spaced strobes.
        do_clear(1'b0, 16'd0);
        for (int i = 0; i < 12; i++) begin
            send(16'(100 + 13 * i), 16'(2000 - 37 * i));
            idle(gaps[i % 4]);
        end
        idle(3);

        // Asynchronous reset in the middle of a cycle while in RUN.
        send(16'd1234, 16'd4321);
        @(posedge clk);
        #3;
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        model_flush();
        #1;
        check("async_rst_avg_current", avg_current, 0);
        check("async_rst_avg_voltage", avg_voltage, 0);
        check("async_rst_avg_valid", avg_valid, 0);
        check("async_rst_window_full", window_full, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH - 1; i++) send(16'd50, 16'd60);
        idle(5);
        check("seven_after_reset_full", window_full, 0);
        send(16'd50, 16'd60);
        idle(4);
        check("eighth_after_reset_avg", avg_current, 50);

        idle(3);
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
